branch_target_predictor: RTL and testbench

Direct-mapped branch target buffer with per-entry 2-bit saturating counters. It sits directly upstream of the fetch stage and supplies `pred`/`pred_addr` for the current fetch PC in the same cycle. It is trained by resolved control-flow instructions from the execute/writeback side and reports mispredictions back to fetch as `br_miss`.

---
 rtl/branch_target_predictor.sv | 145 ++++++++++++++
 tb/tb_branch_target_predictor.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Define BTB_STATS_EN to add the stat_lookups/stat_hits/stat_miss counters.
module branch_target_predictor #(
    parameter  int ENTRIES = 64,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] lookup_pc,
    output logic        pred,
    output logic [31:0] pred_addr,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred,
    input  logic [31:0] upd_pred_addr,
    input  logic        flush,
`ifdef BTB_STATS_EN
    output logic [31:0] stat_lookups,
    output logic [31:0] stat_hits,
    output logic [31:0] stat_miss,
`endif
    output logic        br_miss
);

    localparam int TAG_W = 32 - IDX_W - 2;

    logic               valid_q  [ENTRIES];
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];

    logic [IDX_W-1:0]   lk_idx;
    logic [TAG_W-1:0]   lk_tag;
    logic               lk_hit;
    logic [IDX_W-1:0]   up_idx;
    logic [TAG_W-1:0]   up_tag;
    logic               up_hit;

    logic               wr_en;
    logic [TAG_W-1:0]   wr_tag_d;
    logic [31:0]        wr_target_d;
    logic [1:0]         wr_ctr_d;

    logic               unused_pc_lsbs;

    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == 2'd3) ? 2'd3 : c + 2'd1;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == 2'd0) ? 2'd0 : c - 2'd1;
    endfunction

    // Instructions are word aligned; the two low PC bits carry no information.
    assign unused_pc_lsbs = ^{lookup_pc[1:0], upd_pc[1:0]};

    assign lk_idx    = lookup_pc[IDX_W+1:2];
    assign lk_tag    = lookup_pc[31:IDX_W+2];
    assign lk_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign pred      = lk_hit && ctr_q[lk_idx][1];
    assign pred_addr = pred ? target_q[lk_idx] : 32'd0;

    assign up_idx = upd_pc[IDX_W+1:2];
    assign up_tag = upd_pc[31:IDX_W+2];
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    assign br_miss = upd_valid &&
                     ((upd_taken != upd_pred) ||
                      (upd_taken && (upd_pred_addr != upd_target)));

    always_comb begin
        wr_en       = 1'b0;
        wr_tag_d    = up_tag;
        wr_target_d = target_q[up_idx];
        wr_ctr_d    = ctr_q[up_idx];
        if (upd_valid && !flush) begin
            if (up_hit) begin
                wr_en = 1'b1;
                if (upd_taken) begin
                    wr_ctr_d    = ctr_inc(ctr_q[up_idx]);
                    wr_target_d = upd_target;
                end else begin
                    wr_ctr_d    = ctr_dec(ctr_q[up_idx]);
                end
            end else if (upd_taken) begin
                // Allocation starts weakly taken so the next lookup predicts taken.
                wr_en       = 1'b1;
                wr_target_d = upd_target;
                wr_ctr_d    = 2'd2;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= 32'd0;
                ctr_q[i]    <= 2'd1;
            end
        end else if (flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else if (wr_en) begin
            valid_q[up_idx]  <= 1'b1;
            tag_q[up_idx]    <= wr_tag_d;
            target_q[up_idx] <= wr_target_d;
            ctr_q[up_idx]    <= wr_ctr_d;
        end
    end

`ifdef BTB_STATS_EN
    logic [31:0] stat_lookups_q, stat_lookups_d;
    logic [31:0] stat_hits_q,    stat_hits_d;
    logic [31:0] stat_miss_q,    stat_miss_d;

    // Counters wrap naturally at 32 bits and survive flush.
    always_comb begin
        stat_lookups_d = stat_lookups_q + 32'd1;
        stat_hits_d    = stat_hits_q + {31'd0, lk_hit};
        stat_miss_d    = stat_miss_q + {31'd0, br_miss};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_lookups_q <= 32'd0;
            stat_hits_q    <= 32'd0;
            stat_miss_q    <= 32'd0;
        end else begin
            stat_lookups_q <= stat_lookups_d;
            stat_hits_q    <= stat_hits_d;
            stat_miss_q    <= stat_miss_d;
        end
    end

    assign stat_lookups = stat_lookups_q;
    assign stat_hits    = stat_hits_q;
    assign stat_miss    = stat_miss_q;
`endif

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed vector bench for branch_target_predictor (default 64-entry build).
module tb_branch_target_predictor;

    logic        clk;
    logic        rst;
    logic [31:0] lookup_pc;
    logic        pred;
    logic [31:0] pred_addr;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred;
    logic [31:0] upd_pred_addr;
    logic        flush;
    logic        br_miss;
`ifdef BTB_STATS_EN
    logic [31:0] stat_lookups;
    logic [31:0] stat_hits;
    logic [31:0] stat_miss;
`endif

    branch_target_predictor #(.ENTRIES(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .lookup_pc    (lookup_pc),
        .pred         (pred),
        .pred_addr    (pred_addr),
        .upd_valid    (upd_valid),
        .upd_pc       (upd_pc),
        .upd_taken    (upd_taken),
        .upd_target   (upd_target),
        .upd_pred     (upd_pred),
        .upd_pred_addr(upd_pred_addr),
        .flush        (flush),
`ifdef BTB_STATS_EN
        .stat_lookups (stat_lookups),
        .stat_hits    (stat_hits),
        .stat_miss    (stat_miss),
`endif
        .br_miss      (br_miss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic        up;
        logic [31:0] upa;
        logic        fl;
        logic [31:0] lpc;
        logic        ep;
        logic [31:0] ea;
        logic        em;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(logic uv, logic [31:0] upc, logic ut, logic [31:0] utgt,
                                logic up, logic [31:0] upa, logic fl, logic [31:0] lpc,
                                logic ep, logic [31:0] ea, logic em);
        vec_t v;
        v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt; v.up = up; v.upa = upa;
        v.fl = fl; v.lpc = lpc; v.ep = ep; v.ea = ea; v.em = em;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        upd_valid     = v.uv;
        upd_pc        = v.upc;
        upd_taken     = v.ut;
        upd_target    = v.utgt;
        upd_pred      = v.up;
        upd_pred_addr = v.upa;
        flush         = v.fl;
        lookup_pc     = v.lpc;
    endtask

    task automatic idle(input logic [31:0] lpc);
        drive(mk(0, 0, 0, 0, 0, 0, 0, lpc, 0, 0, 0));
    endtask

    initial begin
        //        uv upc           ut utgt         up upa          fl lpc           ep ea           em
        vecs.push_back(mk(1, 32'h40, 0, 32'h0,   0, 32'h0,   0, 32'h40, 0, 32'h0,   0)); // 0: NT miss, no alloc
        vecs.push_back(mk(1, 32'h40, 1, 32'h100, 0, 32'h0,   0, 32'h40, 0, 32'h0,   1)); // 1: alloc ctr=2
        vecs.push_back(mk(0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 32'h40, 1, 32'h100, 0)); // 2
        vecs.push_back(mk(1, 32'h40, 0, 32'h0,   1, 32'h100, 0, 32'h40, 1, 32'h100, 1)); // 3: ctr->1
        vecs.push_back(mk(1, 32'h40, 0, 32'h0,   0, 32'h0,   0, 32'h40, 0, 32'h0,   0)); // 4: ctr->0
        vecs.push_back(mk(1, 32'h40, 1, 32'h100, 0, 32'h0,   0, 32'h40, 0, 32'h0,   1)); // 5: ctr->1
        vecs.push_back(mk(1, 32'h40, 1, 32'h100, 0, 32'h0,   0, 32'h40, 0, 32'h0,   1)); // 6: ctr->2
        vecs.push_back(mk(1, 32'h40, 1, 32'h100, 1, 32'h100, 0, 32'h40, 1, 32'h100, 0)); // 7: ctr->3
        vecs.push_back(mk(1, 32'h40, 1, 32'h100, 1, 32'h100, 0, 32'h40, 1, 32'h100, 0)); // 8: stays 3
        vecs.push_back(mk(1, 32'h40, 0, 32'h0,   1, 32'h100, 0, 32'h40, 1, 32'h100, 1)); // 9: ctr->2
        vecs.push_back(mk(1, 32'h40, 0, 32'h0,   1, 32'h100, 0, 32'h40, 1, 32'h100, 1)); // 10: ctr->1
        vecs.push_back(mk(0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 32'h40, 0, 32'h0,   0)); // 11
        vecs.push_back(mk(1, 32'h40, 0, 32'h0,   0, 32'h0,   0, 32'h40, 0, 32'h0,   0)); // 12: ctr->0
        vecs.push_back(mk(1, 32'h40, 0, 32'h0,   0, 32'h0,   0, 32'h40, 0, 32'h0,   0)); // 13: stays 0
        vecs.push_back(mk(1, 32'h40, 1, 32'h100, 0, 32'h0,   0, 32'h40, 0, 32'h0,   1)); // 14: ctr->1
        vecs.push_back(mk(0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 32'h40, 0, 32'h0,   0)); // 15
        vecs.push_back(mk(1, 32'h40, 1, 32'h100, 0, 32'h0,   0, 32'h40, 0, 32'h0,   1)); // 16: ctr->2
        vecs.push_back(mk(0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 32'h40, 1, 32'h100, 0)); // 17
        vecs.push_back(mk(1, 32'h140,1, 32'h200, 0, 32'h0,   0, 32'h140,0, 32'h0,   1)); // 18: alias overwrite
        vecs.push_back(mk(0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 32'h40, 0, 32'h0,   0)); // 19
        vecs.push_back(mk(0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 32'h140,1, 32'h200, 0)); // 20
        vecs.push_back(mk(1, 32'h80, 1, 32'h300, 0, 32'h0,   0, 32'h80, 0, 32'h0,   1)); // 21: same-cycle
        vecs.push_back(mk(0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 32'h80, 1, 32'h300, 0)); // 22
        vecs.push_back(mk(1, 32'h80, 1, 32'h304, 1, 32'h300, 0, 32'h80, 1, 32'h300, 1)); // 23: wrong target
        vecs.push_back(mk(0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 32'h80, 1, 32'h304, 0)); // 24
        vecs.push_back(mk(0, 32'h80, 1, 32'h999, 0, 32'h0,   0, 32'h80, 1, 32'h304, 0)); // 25: no upd_valid
        vecs.push_back(mk(1, 32'h40, 1, 32'h500, 0, 32'h0,   1, 32'h80, 1, 32'h304, 1)); // 26: flush+upd
        vecs.push_back(mk(0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 32'h80, 0, 32'h0,   0)); // 27
        vecs.push_back(mk(0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 32'h40, 0, 32'h0,   0)); // 28
        vecs.push_back(mk(0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 32'h140,0, 32'h0,   0)); // 29
        vecs.push_back(mk(1, 32'h140,0, 32'h0,   0, 32'h0,   0, 32'h140,0, 32'h0,   0)); // 30: stale NT
        vecs.push_back(mk(0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 32'h140,0, 32'h0,   0)); // 31
        vecs.push_back(mk(1, 32'hC2, 1, 32'h700, 0, 32'h0,   0, 32'hC0, 0, 32'h0,   1)); // 32: low bits
        vecs.push_back(mk(0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 32'hC1, 1, 32'h700, 0)); // 33
        vecs.push_back(mk(1, 32'hFFFFFFC0, 1, 32'h800, 0, 32'h0, 0, 32'hC0, 1, 32'h700, 1)); // 34
        vecs.push_back(mk(0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 32'hC0, 0, 32'h0,   0)); // 35
        vecs.push_back(mk(0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 32'hFFFFFFC0, 1, 32'h800, 0)); // 36

        rst = 1'b0;
        idle(32'h40);
        #3;
        check("reset pred", {31'd0, pred}, 32'd0);
        check("reset pred_addr", pred_addr, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            check($sformatf("v%0d pred", i), {31'd0, pred}, {31'd0, vecs[i].ep});
            check($sformatf("v%0d pred_addr", i), pred_addr, vecs[i].ea);
            check($sformatf("v%0d br_miss", i), {31'd0, br_miss}, {31'd0, vecs[i].em});
        end

        // Asynchronous reset between edges.
        @(negedge clk);
        idle(32'hFFFFFFC0);
        #1;
        check("pre-rst pred", {31'd0, pred}, 32'd1);
        #1;
        rst = 1'b0;
        #1;
        check("async rst pred", {31'd0, pred}, 32'd0);
        check("async rst pred_addr", pred_addr, 32'd0);

        // Update held across an edge while in reset is dropped; br_miss still combinational.
        drive(mk(1, 32'h40, 1, 32'h900, 0, 32'h0, 0, 32'h40, 0, 32'h0, 1));
        #1;
        check("rst br_miss", {31'd0, br_miss}, 32'd1);
        @(negedge clk);
        check("rst drop pred", {31'd0, pred}, 32'd0);
        rst = 1'b1;
        #1;
        check("post-rst pred", {31'd0, pred}, 32'd0);
        @(negedge clk);
        idle(32'h40);
        #1;
        check("first upd pred", {31'd0, pred}, 32'd1);
        check("first upd addr", pred_addr, 32'h900);
        lookup_pc = 32'hFFFFFFC0;
        #1;
        check("cleared entry pred", {31'd0, pred}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
